// File: rtl/dtag_bist_ctl_pkg.sv
// Shared encodings for the D$ tag/status march BIST: element codes,
// per-element direction and read/write patterns, and FSM states.
package dtag_bist_ctl_pkg;

  localparam int unsigned ELEM_W = 3;

  typedef logic [ELEM_W-1:0] elem_t;

  localparam elem_t E_UP_W0   = 3'd0;
  localparam elem_t E_UP_R0W1 = 3'd1;
  localparam elem_t E_UP_R1W0 = 3'd2;
  localparam elem_t E_DN_R0W1 = 3'd3;
  localparam elem_t E_DN_R1W0 = 3'd4;
  localparam elem_t E_DN_R0   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic elem_down(input elem_t e);
    return (e >= E_DN_R0W1);
  endfunction

  function automatic logic elem_has_rd(input elem_t e);
    return (e != E_UP_W0);
  endfunction

  function automatic logic elem_has_wr(input elem_t e);
    return (e != E_DN_R0);
  endfunction

  // 1 selects the all-ones pattern P1, 0 selects P0
  function automatic logic elem_rd_pat(input elem_t e);
    return (e == E_UP_R1W0) || (e == E_DN_R1W0);
  endfunction

  function automatic logic elem_wr_pat(input elem_t e);
    return (e == E_UP_R0W1) || (e == E_DN_R0W1);
  endfunction

endpackage

// File: rtl/dtag_bist_ctl_cmp.sv
// Read-data checker: registers the expected pattern for each read, compares the
// returned tag/status one cycle later and keeps a sticky error with first-fail capture.
module dtag_bist_cmp
  import dtag_bist_ctl_pkg::*;
#(
  parameter int unsigned TAG_W  = 19,
  parameter int unsigned STAT_W = 5,
  parameter int unsigned LOC_W  = 10
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              i_clr,
  input  logic              i_cap_vld,
  input  logic              i_cap_pat,
  input  logic [LOC_W-1:0]  i_cap_loc,
  input  elem_t             i_cap_elem,
  input  logic [TAG_W-1:0]  i_dtag_dout,
  input  logic [STAT_W-1:0] i_stat_out,
  output logic              o_err_l,
  output logic [LOC_W-1:0]  o_fail_addr,
  output elem_t             o_fail_elem
);

  logic             r_vld;
  logic             r_pat;
  logic [LOC_W-1:0] r_loc;
  elem_t            r_elem;
  logic             r_err_l;
  logic [LOC_W-1:0] r_fail_addr;
  elem_t            r_fail_elem;
  logic             w_miss;

  assign w_miss = r_vld &&
                  ((i_dtag_dout != {TAG_W{r_pat}}) || (i_stat_out != {STAT_W{r_pat}}));

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_vld       <= 1'b0;
      r_pat       <= 1'b0;
      r_loc       <= '0;
      r_elem      <= '0;
      r_err_l     <= 1'b1;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
    end else begin
      r_vld  <= i_cap_vld && !i_clr;
      r_pat  <= i_cap_pat;
      r_loc  <= i_cap_loc;
      r_elem <= i_cap_elem;
      if (i_clr) begin
        r_err_l     <= 1'b1;
        r_fail_addr <= '0;
        r_fail_elem <= '0;
      end else if (w_miss && r_err_l) begin
        r_err_l     <= 1'b0;
        r_fail_addr <= r_loc;
        r_fail_elem <= r_elem;
      end
    end
  end

  assign o_err_l     = r_err_l;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_elem = r_fail_elem;

endmodule

// File: rtl/dtag_bist_ctl.sv
// March-test BIST initiator for the two-way D$ tag/status array: sequences the
// six march elements over {way,index} and drives the array write/read ports.
module dtag_bist_ctl
  import dtag_bist_ctl_pkg::*;
#(
  parameter int unsigned TAG_W  = 19,
  parameter int unsigned IDX_W  = 9,
  parameter int unsigned STAT_W = 5
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              bist_start,
  input  logic              bist_abort,
  output logic [TAG_W-1:0]  tag_in,
  output logic              tag_we,
  output logic [STAT_W-1:0] stat_in,
  output logic [STAT_W-1:0] stat_we,
  output logic [IDX_W-1:0]  addr,
  output logic              set_sel,
  output logic              wb_set_sel,
  input  logic [TAG_W-1:0]  dtag_dout,
  input  logic [STAT_W-1:0] stat_out,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_err_l,
  output logic [IDX_W:0]    fail_addr,
  output logic [2:0]        fail_elem
);

  localparam int unsigned      LOC_W   = IDX_W + 1;
  localparam logic [LOC_W-1:0] LOC_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  elem_t            r_elem;
  elem_t            w_elem_nxt;
  elem_t            w_elem_inc;
  logic [LOC_W-1:0] r_loc;
  logic [LOC_W-1:0] w_loc_nxt;
  logic [LOC_W-1:0] w_loc_step;
  logic             w_last;
  logic             w_start;
  logic             w_wr;
  logic             w_cap_vld;

  assign w_elem_inc = r_elem + elem_t'(1);
  assign w_loc_step = elem_down(r_elem) ? (r_loc - LOC_W'(1)) : (r_loc + LOC_W'(1));
  assign w_last     = elem_down(r_elem) ? (r_loc == '0) : (r_loc == LOC_MAX);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
      r_elem  <= E_UP_W0;
      r_loc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_loc   <= w_loc_nxt;
    end
  end

  // Element switch happens on the last write of an element, so there is no bubble
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_loc_nxt   = r_loc;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bist_start) begin
          w_state_nxt = ST_WR;
          w_elem_nxt  = E_UP_W0;
          w_loc_nxt   = '0;
          w_start     = 1'b1;
        end
      end
      ST_WR: begin
        if (w_last) begin
          w_state_nxt = ST_RD;
          w_elem_nxt  = w_elem_inc;
          w_loc_nxt   = elem_down(w_elem_inc) ? LOC_MAX : '0;
        end else begin
          w_state_nxt = elem_has_rd(r_elem) ? ST_RD : ST_WR;
          w_loc_nxt   = w_loc_step;
        end
      end
      ST_RD: begin
        if (elem_has_wr(r_elem)) begin
          w_state_nxt = ST_WR;
        end else if (w_last) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_loc_nxt = w_loc_step;
        end
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_elem_nxt  = E_UP_W0;
        w_loc_nxt   = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bist_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_elem_nxt  = E_UP_W0;
      w_loc_nxt   = '0;
    end
  end

  // Abort gates the write enables in the same cycle it is sampled
  assign w_wr       = (r_state == ST_WR);
  assign tag_we     = w_wr && !bist_abort;
  assign stat_we    = {STAT_W{tag_we}};
  assign tag_in     = {TAG_W{w_wr && elem_wr_pat(r_elem)}};
  assign stat_in    = {STAT_W{w_wr && elem_wr_pat(r_elem)}};
  assign addr       = r_loc[IDX_W-1:0];
  assign set_sel    = r_loc[IDX_W];
  assign wb_set_sel = r_loc[IDX_W];
  assign bist_busy  = (r_state == ST_WR) || (r_state == ST_RD) || (r_state == ST_FLUSH);
  assign bist_done  = (r_state == ST_DONE);
  assign w_cap_vld  = (r_state == ST_RD) && !bist_abort;

  dtag_bist_cmp #(
    .TAG_W  (TAG_W),
    .STAT_W (STAT_W),
    .LOC_W  (LOC_W)
  ) u_cmp (
    .clk         (clk),
    .reset_l     (reset_l),
    .i_clr       (w_start),
    .i_cap_vld   (w_cap_vld),
    .i_cap_pat   (elem_rd_pat(r_elem)),
    .i_cap_loc   (r_loc),
    .i_cap_elem  (r_elem),
    .i_dtag_dout (dtag_dout),
    .i_stat_out  (stat_out),
    .o_err_l     (bist_err_l),
    .o_fail_addr (fail_addr),
    .o_fail_elem (fail_elem)
  );

endmodule
